inv_mix_columns_seq: RTL

Iterative AES InvMixColumns unit for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and applies the inverse column matrix [0e 0b 0d 09] over GF(2^8), using the polynomial x^8+x^4+x^3+x+1 (0x11b). It processes COLS_PER_CYCLE columns per clock through a shared datapath and returns the result over a second valid/ready handshake. It sits between inverse ShiftRows/SubBytes/AddRoundKey in the lightweight decryption round, and its byte and column layout matches the forward mix-columns stage.

---
 rtl/inv_mix_columns_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns, iterating COLS_PER_CYCLE columns per clock over a shared datapath.
// Latency: 4/COLS_PER_CYCLE cycles from accept to out_valid; one state per N+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no same-cycle re-accept.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int N  = 4 / COLS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  col_cnt;
  logic [127:0]   work;
  logic [127:0]   work_nxt;
  logic [1:0]     col;
  logic           last_grp;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    a[0] = c[31:24];
    a[1] = c[23:16];
    a[2] = c[15:8];
    a[3] = c[7:0];
    for (int i = 0; i < 4; i++) begin
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Columns of the current group are rewritten in place; the rest pass through.
  always_comb begin
    work_nxt = work;
    col      = '0;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col = 2'(int'(col_cnt) * COLS_PER_CYCLE + g);
      work_nxt[{col, 5'b0} +: 32] = inv_col(work[{col, 5'b0} +: 32]);
    end
  end

  assign last_grp  = (col_cnt == CW'(N - 1));
  assign state_out = work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      work      <= '0;
      col_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= state_in;
            col_cnt  <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          work <= work_nxt;
          if (last_grp) begin
            col_cnt   <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
